// File: rtl/alarm_pkg.sv
// Shared types for the alarm beep-pattern generator.
// Holds the FSM state encoding and the gap-length helper.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ON     = 3'd1,
    ST_OFF    = 3'd2,
    ST_GAP    = 3'd3,
    ST_SNOOZE = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Silence after the last beep that pads a burst out to its period.
  function automatic int gap_ms(
    input int period,
    input int beeps,
    input int on_ms,
    input int off_ms
  );
    return period - beeps * on_ms - (beeps - 1) * off_ms;
  endfunction

endpackage

// File: rtl/alarm_pattern_gen_ms_phase_timer.sv
// ms_phase_timer: counts msTick pulses within one alarm phase.
// Ports: uclock, nReset (sync, low), clr, tick, term -> expire.
module ms_phase_timer
  import alarm_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic             uclock,
  input  logic             nReset,
  input  logic             clr,
  input  logic             tick,
  input  logic [CNT_W-1:0] term,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  // Clear wins over a coincident tick: a new phase starts at zero.
  always_ff @(posedge uclock) begin
    if (!nReset || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Expire on the tick that completes the phase (count term+1).
  assign expire = tick && (cnt == term);

endmodule

// File: rtl/alarm_pattern_gen.sv
// Alarm beep-pattern generator: bursts of BEEPS beeps on a 1 ms tick,
// with snooze, burst limit / auto-stop and burst status.
// Ports: uclock, nReset (sync, low), msTick, tobuzzer, snooze ->
//        buzzer, active, burstCount.
// Option: ALARM_TONE_EN adds TONE_DIV and a square-wave tone in ON.
module alarm_pattern_gen
  import alarm_pkg::*;
#(
  parameter int CNT_W      = 12,
  parameter int BEEPS      = 4,
  parameter int ON_MS      = 80,
  parameter int OFF_MS     = 60,
  parameter int PERIOD_MS  = 1020,
  parameter int SNOOZE_MS  = 3000,
  parameter int MAX_BURSTS = 0,
  parameter int BURST_W    = 8
`ifdef ALARM_TONE_EN
  ,
  parameter int TONE_DIV   = 4
`endif
) (
  input  logic               uclock,
  input  logic               nReset,
  input  logic               msTick,
  input  logic               tobuzzer,
  input  logic               snooze,
  output logic               buzzer,
  output logic               active,
  output logic [BURST_W-1:0] burstCount
);

  localparam int GAP_MS =
    gap_ms(PERIOD_MS, BEEPS, ON_MS, OFF_MS);

  localparam logic [CNT_W-1:0] T_ON  = CNT_W'(ON_MS - 1);
  localparam logic [CNT_W-1:0] T_OFF = CNT_W'(OFF_MS - 1);
  localparam logic [CNT_W-1:0] T_GAP = CNT_W'(GAP_MS - 1);
  localparam logic [CNT_W-1:0] T_SNZ = CNT_W'(SNOOZE_MS - 1);

  localparam logic [3:0] LAST_IDX = 4'(BEEPS - 1);

  localparam bit LIMIT = (MAX_BURSTS != 0);
  localparam logic [BURST_W-1:0] MAXB = BURST_W'(MAX_BURSTS);

  state_t             state;
  state_t             nxt;
  logic [3:0]         idx;
  logic [BURST_W-1:0] bcnt_inc;
  logic [CNT_W-1:0]   term;
  logic               expire;
  logic               clr;
  logic               gap_done;
  logic               tone_lvl;
  logic               buz_d;
  logic               act_d;

  assign bcnt_inc = (&burstCount) ? burstCount
                                  : burstCount + 1'b1;

  // ---- state register ----
  always_ff @(posedge uclock) begin
    if (!nReset) begin
      state <= ST_IDLE;
    end else begin
      state <= nxt;
    end
  end

  // ---- next state ----
  // Priority: alarm off, then snooze, then phase expiry.
  always_comb begin
    nxt = state;
    if (!tobuzzer) begin
      nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: nxt = ST_ON;
        ST_ON: begin
          if (snooze) begin
            nxt = ST_SNOOZE;
          end else if (expire) begin
            nxt = (idx == LAST_IDX) ? ST_GAP : ST_OFF;
          end
        end
        ST_OFF: begin
          if (snooze) begin
            nxt = ST_SNOOZE;
          end else if (expire) begin
            nxt = ST_ON;
          end
        end
        ST_GAP: begin
          if (snooze) begin
            nxt = ST_SNOOZE;
          end else if (expire) begin
            nxt = (LIMIT && bcnt_inc == MAXB) ? ST_DONE
                                              : ST_ON;
          end
        end
        ST_SNOOZE: begin
          if (snooze) begin
            nxt = ST_SNOOZE;
          end else if (expire) begin
            nxt = ST_ON;
          end
        end
        ST_DONE: nxt = ST_DONE;
        default: nxt = ST_IDLE;
      endcase
    end
  end

  // ---- phase timer ----
  always_comb begin
    term = '0;
    unique case (state)
      ST_ON:     term = T_ON;
      ST_OFF:    term = T_OFF;
      ST_GAP:    term = T_GAP;
      ST_SNOOZE: term = T_SNZ;
      default:   term = '0;
    endcase
  end

  // A repeated snooze restarts the timer without a state change.
  assign clr = (nxt != state) ||
               (nxt == ST_SNOOZE && snooze);

  ms_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .uclock (uclock),
    .nReset (nReset),
    .clr    (clr),
    .tick   (msTick),
    .term   (term),
    .expire (expire)
  );

  // ---- beep index ----
  always_ff @(posedge uclock) begin
    if (!nReset) begin
      idx <= '0;
    end else if (nxt == ST_ON && state == ST_OFF) begin
      idx <= idx + 1'b1;
    end else if (nxt == ST_ON && state != ST_ON) begin
      idx <= '0;
    end
  end

  // ---- burst counter ----
  assign gap_done = (state == ST_GAP) && expire &&
                    tobuzzer && !snooze;

  always_ff @(posedge uclock) begin
    if (!nReset || !tobuzzer) begin
      burstCount <= '0;
    end else if (gap_done) begin
      burstCount <= bcnt_inc;
    end
  end

  // ---- tone level while in ON ----
`ifdef ALARM_TONE_EN
  logic [TONE_DIV:0] tcnt;
  logic [TONE_DIV:0] tcnt_d;

  // Restarts from zero on ON entry so the first half-cycle is high.
  assign tcnt_d = (state != ST_ON) ? '0 : tcnt + 1'b1;

  always_ff @(posedge uclock) begin
    if (!nReset) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt_d;
    end
  end

  assign tone_lvl = ~tcnt_d[TONE_DIV];
`else
  assign tone_lvl = 1'b1;
`endif

  // ---- outputs, decoded from next state then registered ----
  always_comb begin
    buz_d = 1'b0;
    act_d = 1'b0;
    unique case (nxt)
      ST_ON: begin
        buz_d = tone_lvl;
        act_d = 1'b1;
      end
      ST_OFF, ST_GAP, ST_SNOOZE: act_d = 1'b1;
      default: begin
        buz_d = 1'b0;
        act_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge uclock) begin
    if (!nReset) begin
      buzzer <= 1'b0;
      active <= 1'b0;
    end else begin
      buzzer <= buz_d;
      active <= act_d;
    end
  end

endmodule
